// File: rtl/expr_pkg.sv
// rtl/expr_pkg.sv - shared types and ASCII constants for the expression stream checker
package expr_pkg;

    typedef enum logic [1:0] {
        S_OPND,
        S_NUM,
        S_CLOSE,
        S_ERR
    } state_t;

    typedef enum logic [2:0] {
        C_DIGIT,
        C_OP,
        C_LP,
        C_RP,
        C_OTHER
    } char_class_t;

    localparam logic [7:0] ASCII_0      = 8'h30;
    localparam logic [7:0] ASCII_9      = 8'h39;
    localparam logic [7:0] ASCII_PLUS   = 8'h2B;
    localparam logic [7:0] ASCII_MINUS  = 8'h2D;
    localparam logic [7:0] ASCII_STAR   = 8'h2A;
    localparam logic [7:0] ASCII_SLASH  = 8'h2F;
    localparam logic [7:0] ASCII_LPAREN = 8'h28;
    localparam logic [7:0] ASCII_RPAREN = 8'h29;

endpackage

// File: rtl/expr_char_class.sv
// rtl/expr_char_class.sv - combinational ASCII byte classifier
module expr_char_class
    import expr_pkg::*;
(
    input  logic [7:0]  in,
    output char_class_t cls
);

    always_comb begin
        cls = C_OTHER;
        if (in >= ASCII_0 && in <= ASCII_9) begin
            cls = C_DIGIT;
        end else begin
            case (in)
                ASCII_PLUS, ASCII_MINUS, ASCII_STAR, ASCII_SLASH: cls = C_OP;
                ASCII_LPAREN:                                     cls = C_LP;
                ASCII_RPAREN:                                     cls = C_RP;
                default:                                          cls = C_OTHER;
            endcase
        end
    end

endmodule

// File: rtl/expr_stream_checker.sv
// rtl/expr_stream_checker.sv - recognises legal arithmetic expressions in a byte stream
module expr_stream_checker
    import expr_pkg::*;
#(
    parameter int MAX_DIGITS  = 4,
    parameter int MAX_DEPTH   = 7,
    parameter int DEPTH_W     = 3,
    parameter int STRICT_ZERO = 0
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               in_valid,
    input  logic [7:0]         in,
    output logic               out,
    output logic               err,
    output logic [DEPTH_W-1:0] depth
);

    localparam int CNT_W = $clog2(MAX_DIGITS + 1);

    state_t             state;
    char_class_t        cls;
    logic [CNT_W-1:0]   cnt;
    logic               lead_zero;
    logic [DEPTH_W-1:0] depth_q;

    expr_char_class u_class (
        .in  (in),
        .cls (cls)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= S_OPND;
            cnt       <= '0;
            lead_zero <= 1'b0;
            depth_q   <= '0;
        end else if (in_valid) begin
            case (state)
                S_OPND: begin
                    case (cls)
                        C_DIGIT: begin
                            state     <= S_NUM;
                            cnt       <= CNT_W'(1);
                            lead_zero <= (in == ASCII_0);
                        end
                        C_LP: begin
                            // Overflow is caught before the increment so depth never wraps.
                            if (depth_q == DEPTH_W'(MAX_DEPTH)) state <= S_ERR;
                            else                                depth_q <= depth_q + DEPTH_W'(1);
                        end
                        default: state <= S_ERR;
                    endcase
                end
                S_NUM: begin
                    case (cls)
                        C_DIGIT: begin
                            if (cnt == CNT_W'(MAX_DIGITS) || ((STRICT_ZERO != 0) && lead_zero))
                                state <= S_ERR;
                            else
                                cnt <= cnt + CNT_W'(1);
                        end
                        C_OP: begin
                            state <= S_OPND;
                            cnt   <= '0;
                        end
                        C_RP: begin
                            if (depth_q == '0) begin
                                state <= S_ERR;
                            end else begin
                                depth_q <= depth_q - DEPTH_W'(1);
                                state   <= S_CLOSE;
                            end
                        end
                        default: state <= S_ERR;
                    endcase
                end
                S_CLOSE: begin
                    case (cls)
                        C_OP: begin
                            state <= S_OPND;
                            cnt   <= '0;
                        end
                        C_RP: begin
                            if (depth_q == '0) begin
                                state <= S_ERR;
                            end else begin
                                depth_q <= depth_q - DEPTH_W'(1);
                                state   <= S_CLOSE;
                            end
                        end
                        default: state <= S_ERR;
                    endcase
                end
                default: state <= S_ERR;
            endcase
        end
    end

    assign out   = ((state == S_NUM) || (state == S_CLOSE)) && (depth_q == '0);
    assign err   = (state == S_ERR);
    assign depth = depth_q;

endmodule
